// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI response encodings, defaults and arbiter state type.
package axi_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int DEF_IDW = 8;
  typedef enum logic {IDLE, BUSY} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first request searching upward from last+1.
module rr_pick #(
  parameter int NUM_S = 3,
  localparam int LW = $clog2(NUM_S)
) (
  input  logic [NUM_S-1:0] req,
  input  logic [LW-1:0]    last,
  output logic [NUM_S-1:0] win,
  output logic             vld
);
  always_comb begin
    win = '0;
    vld = 1'b0;
    for (int k = 1; k <= NUM_S; k++)
      for (int i = 0; i < NUM_S; i++)
        if (!vld && req[i] && (int'(last) + k) % NUM_S == i) begin
          win[i] = 1'b1;
          vld = 1'b1;
        end
  end
endmodule

// File: rtl/axi_b_arbiter.sv
// axi_b_arbiter: round-robin B-channel arbiter with per-slave outstanding-write tracking.
// Define AXI_B_BACK2BACK_EN to re-arbitrate on the handshake cycle with no IDLE bubble.
module axi_b_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_S = 3,
  parameter int IDW = DEF_IDW,
  parameter int CNTW = 4
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               aw_fire,
  input  logic [NUM_S-1:0]   aw_sel,
  input  logic [NUM_S-1:0]   BVALID_S,
  input  logic [NUM_S*IDW-1:0] BID_S,
  input  logic [NUM_S*2-1:0] BRESP_S,
  output logic [NUM_S-1:0]   BREADY_S,
  output logic               BVALID_M,
  output logic [IDW-1:0]     BID_M,
  output logic [1:0]         BRESP_M,
  input  logic               BREADY_M,
  output logic [NUM_S-1:0]   grant,
  output logic [NUM_S-1:0]   aw_full,
  output logic               err
);
  localparam int LW = $clog2(NUM_S);
  arb_state_t state, state_n;
  logic [NUM_S-1:0] grant_n, req, win, dec, inc;
  logic [LW-1:0] last, gidx, pick_last;
  logic [CNTW-1:0] cnt [NUM_S];
  logic vld, hs, sel_ok, err_n;
  always_comb begin
    gidx = '0;
    BVALID_M = 1'b0;
    BID_M = '0;
    BRESP_M = '0;
    for (int i = 0; i < NUM_S; i++)
      if (grant[i]) begin
        gidx = LW'(i);
        BVALID_M = BVALID_S[i];
        BID_M = BID_S[i*IDW +: IDW];
        BRESP_M = BRESP_S[i*2 +: 2];
      end
  end
  assign BREADY_S = grant & {NUM_S{BREADY_M}};
  assign hs = BVALID_M & BREADY_M;
  assign sel_ok = $onehot(aw_sel);
  assign pick_last = hs ? gidx : last;
  // A slave handshaking this cycle only stays eligible if it has another write pending
  always_comb begin
    aw_full = '0;
    dec = '0;
    inc = '0;
    req = '0;
    for (int i = 0; i < NUM_S; i++) begin
      aw_full[i] = &cnt[i];
      dec[i] = grant[i] & BVALID_S[i] & BREADY_M;
      inc[i] = aw_fire & sel_ok & aw_sel[i] & ~aw_full[i];
      req[i] = BVALID_S[i] & (cnt[i] > CNTW'(dec[i]));
    end
  end
  assign err_n = err | (aw_fire & (~sel_ok | |(aw_sel & aw_full)));
  rr_pick #(.NUM_S(NUM_S)) u_pick (
    .req  (req),
    .last (pick_last),
    .win  (win),
    .vld  (vld)
  );
  always_comb begin
    state_n = state;
    grant_n = grant;
    if (state == IDLE) begin
      state_n = vld ? BUSY : IDLE;
      grant_n = win;
    end else if (hs) begin
`ifdef AXI_B_BACK2BACK_EN
      state_n = vld ? BUSY : IDLE;
      grant_n = win;
`else
      state_n = IDLE;
      grant_n = '0;
`endif
    end
  end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      state <= IDLE;
      grant <= '0;
      last <= LW'(NUM_S - 1);
      err <= 1'b0;
      for (int i = 0; i < NUM_S; i++) cnt[i] <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      err <= err_n;
      if (hs) last <= gidx;
      for (int i = 0; i < NUM_S; i++) cnt[i] <= cnt[i] + CNTW'(inc[i]) - CNTW'(dec[i]);
    end
endmodule

// File: tb/tb_axi_b_arbiter.sv
// tb_axi_b_arbiter: directed vector table plus randomized run against a behavioural model.
module tb_axi_b_arbiter;
  localparam int N = 3, IDW = 8, CNTW = 2, MAXC = 3;
`ifdef AXI_B_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  logic ACLK = 1'b0, ARESET = 1'b1, aw_fire = 1'b0, BREADY_M = 1'b0;
  logic [N-1:0] aw_sel = '0, BVALID_S = '0, BREADY_S, grant, aw_full;
  logic [N*IDW-1:0] BID_S = '0;
  logic [N*2-1:0] BRESP_S = '0;
  logic BVALID_M, err;
  logic [IDW-1:0] BID_M;
  logic [1:0] BRESP_M;
  int n_chk = 0, n_fail = 0;
  int m_cnt [N];
  int m_gnt, m_last;
  bit m_err;

  typedef struct {
    bit rst; bit aw; logic [2:0] sel; logic [2:0] bv; bit br;
    logic [2:0] g; bit bvm; logic [2:0] full; bit e;
  } vec_t;
  vec_t tbl [$];

  axi_b_arbiter #(.NUM_S(N), .IDW(IDW), .CNTW(CNTW)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .aw_fire(aw_fire), .aw_sel(aw_sel),
    .BVALID_S(BVALID_S), .BID_S(BID_S), .BRESP_S(BRESP_S), .BREADY_S(BREADY_S),
    .BVALID_M(BVALID_M), .BID_M(BID_M), .BRESP_M(BRESP_M), .BREADY_M(BREADY_M),
    .grant(grant), .aw_full(aw_full), .err(err)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_gnt = -1;
    m_last = N - 1;
    m_err = 1'b0;
  endtask

  task automatic check_model();
    logic [N-1:0] eg, ebr, ef;
    logic ev;
    logic [IDW-1:0] eid;
    logic [1:0] er, gi;
    eg = '0; ebr = '0; ef = '0; ev = 1'b0; eid = '0; er = '0;
    gi = m_gnt[1:0];
    if (m_gnt >= 0) begin
      eg = 3'(1 << m_gnt);
      ev = BVALID_S[gi];
      eid = IDW'(BID_S >> (m_gnt * IDW));
      er = 2'(BRESP_S >> (m_gnt * 2));
      ebr = BREADY_M ? eg : '0;
    end
    for (int i = 0; i < N; i++) ef[i] = (m_cnt[i] == MAXC);
    chk("grant", 32'(grant), 32'(eg));
    chk("bvalid_m", 32'(BVALID_M), 32'(ev));
    chk("bid_m", 32'(BID_M), 32'(eid));
    chk("bresp_m", 32'(BRESP_M), 32'(er));
    chk("bready_s", 32'(BREADY_S), 32'(ebr));
    chk("aw_full", 32'(aw_full), 32'(ef));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic model_step();
    int nc [N];
    bit hs;
    int og;
    logic [1:0] ogi;
    if (ARESET) begin
      model_reset();
      return;
    end
    nc = m_cnt;
    og = m_gnt;
    ogi = og[1:0];
    hs = og >= 0 && BVALID_S[ogi] && BREADY_M;
    if (aw_fire) begin
      if ($countones(aw_sel) != 1) m_err = 1'b1;
      else for (int i = 0; i < N; i++)
        if (aw_sel[i]) begin
          if (m_cnt[i] == MAXC) m_err = 1'b1;
          else nc[i]++;
        end
    end
    if (hs) begin
      nc[og]--;
      m_last = og;
    end
    if (og < 0 || (hs && B2B)) begin
      m_gnt = -1;
      for (int k = 1; k <= N && m_gnt < 0; k++) begin
        int j = (m_last + k) % N;
        logic [1:0] ji = j[1:0];
        if (BVALID_S[ji] && m_cnt[j] - ((hs && j == og) ? 1 : 0) > 0) m_gnt = j;
      end
    end else if (hs) m_gnt = -1;
    m_cnt = nc;
  endtask

  task automatic cyc();
    @(negedge ACLK);
    check_model();
    @(posedge ACLK);
    model_step();
    #1;
  endtask

  function automatic vec_t mk(bit rst, bit aw, logic [2:0] sel, logic [2:0] bv, bit br,
                              logic [2:0] g, bit bvm, logic [2:0] full, bit e);
    vec_t v;
    v.rst = rst; v.aw = aw; v.sel = sel; v.bv = bv; v.br = br;
    v.g = g; v.bvm = bvm; v.full = full; v.e = e;
    return v;
  endfunction

  initial begin
    int w;
    model_reset();
    BID_S = 24'hC2B1A0;
    BRESP_S = 6'b10_01_00;
    repeat (2) @(posedge ACLK);
    #1;
    // single write to slave 1, stale BVALID ignored
    tbl.push_back(mk(1, 0, 3'b000, 3'b000, 0, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(0, 1, 3'b010, 3'b000, 1, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(0, 0, 3'b000, 3'b010, 1, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(0, 0, 3'b000, 3'b010, 1, 3'b010, 1, 3'b000, 0));
    tbl.push_back(mk(0, 0, 3'b000, 3'b010, 1, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(0, 0, 3'b000, 3'b111, 1, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(0, 0, 3'b000, 3'b111, 1, 3'b000, 0, 3'b000, 0));
    // one write each, service order 0,1,2 with bubbles
    tbl.push_back(mk(1, 0, 3'b000, 3'b000, 0, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(0, 1, 3'b001, 3'b000, 1, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(0, 1, 3'b010, 3'b000, 1, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(0, 1, 3'b100, 3'b000, 1, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(0, 0, 3'b000, 3'b111, 1, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(0, 0, 3'b000, 3'b111, 1, 3'b001, 1, 3'b000, 0));
    tbl.push_back(mk(0, 0, 3'b000, 3'b111, 1, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(0, 0, 3'b000, 3'b111, 1, 3'b010, 1, 3'b000, 0));
    tbl.push_back(mk(0, 0, 3'b000, 3'b111, 1, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(0, 0, 3'b000, 3'b111, 1, 3'b100, 1, 3'b000, 0));
    tbl.push_back(mk(0, 0, 3'b000, 3'b111, 1, 3'b000, 0, 3'b000, 0));
    // slave 2 stalled by BREADY_M=0 while slave 0 becomes eligible
    tbl.push_back(mk(1, 0, 3'b000, 3'b000, 0, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(0, 1, 3'b100, 3'b000, 0, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(0, 0, 3'b000, 3'b100, 0, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(0, 1, 3'b001, 3'b101, 0, 3'b100, 1, 3'b000, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 3'b000, 3'b101, 0, 3'b100, 1, 3'b000, 0));
    tbl.push_back(mk(0, 0, 3'b000, 3'b101, 1, 3'b100, 1, 3'b000, 0));
    tbl.push_back(mk(0, 0, 3'b000, 3'b101, 1, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(0, 0, 3'b000, 3'b101, 1, 3'b001, 1, 3'b000, 0));
    tbl.push_back(mk(0, 0, 3'b000, 3'b001, 1, 3'b000, 0, 3'b000, 0));
    // saturation and non-one-hot select
    tbl.push_back(mk(1, 0, 3'b000, 3'b000, 0, 3'b000, 0, 3'b000, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 3'b001, 3'b000, 0, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(0, 1, 3'b001, 3'b000, 0, 3'b000, 0, 3'b001, 0));
    tbl.push_back(mk(0, 0, 3'b000, 3'b000, 0, 3'b000, 0, 3'b001, 1));
    tbl.push_back(mk(0, 1, 3'b011, 3'b000, 0, 3'b000, 0, 3'b001, 1));
    tbl.push_back(mk(1, 0, 3'b000, 3'b000, 0, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(0, 1, 3'b011, 3'b000, 0, 3'b000, 0, 3'b000, 0));
    tbl.push_back(mk(0, 0, 3'b000, 3'b000, 0, 3'b000, 0, 3'b000, 1));
    tbl.push_back(mk(1, 0, 3'b000, 3'b000, 0, 3'b000, 0, 3'b000, 0));
    foreach (tbl[r]) begin
      ARESET = tbl[r].rst;
      if (tbl[r].rst) model_reset();
      aw_fire = tbl[r].aw;
      aw_sel = tbl[r].sel;
      BVALID_S = tbl[r].bv;
      BREADY_M = tbl[r].br;
      @(negedge ACLK);
      check_model();
      chk($sformatf("vec%0d_grant", r), 32'(grant), 32'(tbl[r].g));
      chk($sformatf("vec%0d_bvalid_m", r), 32'(BVALID_M), 32'(tbl[r].bvm));
      chk($sformatf("vec%0d_aw_full", r), 32'(aw_full), 32'(tbl[r].full));
      chk($sformatf("vec%0d_err", r), 32'(err), 32'(tbl[r].e));
      @(posedge ACLK);
      model_step();
      #1;
    end
    // reset while a response is being presented
    ARESET = 1'b0;
    aw_fire = 1'b1; aw_sel = 3'b011; BVALID_S = '0; BREADY_M = 1'b0;
    cyc();
    aw_sel = 3'b010;
    cyc();
    aw_fire = 1'b0; BVALID_S = 3'b010;
    cyc();
    cyc();
    @(negedge ACLK);
    chk("pre_rst_bvalid_m", 32'(BVALID_M), 32'd1);
    chk("pre_rst_err", 32'(err), 32'd1);
    #1 ARESET = 1'b1;
    model_reset();
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_bvalid_m", 32'(BVALID_M), 32'd0);
    chk("rst_bready_s", 32'(BREADY_S), 32'd0);
    chk("rst_aw_full", 32'(aw_full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge ACLK);
    #1 ARESET = 1'b0;
    BVALID_S = '0;
    aw_fire = 1'b1; aw_sel = 3'b010;
    cyc();
    aw_sel = 3'b001;
    cyc();
    aw_fire = 1'b0; BVALID_S = 3'b011; BREADY_M = 1'b1;
    w = 0;
    while (grant == '0 && w < 8) begin
      cyc();
      w++;
    end
    chk("first_pick_after_rst", 32'(grant), 32'b001);
    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      ARESET = (c % 250 == 0);
      if (ARESET) model_reset();
      aw_fire = ($urandom_range(0, 3) == 0);
      aw_sel = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'(1 << $urandom_range(0, 2));
      BVALID_S = 3'($urandom);
      BREADY_M = ($urandom_range(0, 3) != 0);
      BID_S = 24'($urandom);
      BRESP_S = 6'($urandom);
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_b_arbiter.md
# axi_b_arbiter

Parametrised write-response (B channel) arbiter for the AXI interconnect. It returns the B responses of NUM_S slave ports to one master port. It tracks outstanding writes per slave and arbitrates round-robin among slaves that both hold BVALID and have a write pending. The grant is held until the master handshake completes. It replaces the fixed three-way B-channel grant logic and generalises it to any slave count, with ID/response muxing and error flagging.

## Interface
Parameters:
- NUM_S, 3, number of slave B ports (including the default slave), ≥2
- IDW, 8, BID width
- CNTW, 4, width of each per-slave outstanding-write counter

Ports:
- ACLK  in  1  clock
- ARESET  in  1  reset. One clock; reset is asynchronous and active-high.
- aw_fire  in  1  AW handshake accepted this cycle
- aw_sel  in  NUM_S  one-hot target slave of the accepted AW
- BVALID_S  in  NUM_S  per-slave BVALID
- BID_S  in  NUM_S*IDW  per-slave BID, slave i at [i*IDW +: IDW]
- BRESP_S  in  NUM_S*2  per-slave BRESP, slave i at [i*2 +: 2]
- BREADY_S  out  NUM_S  per-slave BREADY
- BVALID_M  out  1  master BVALID
- BID_M  out  IDW  master BID
- BRESP_M  out  2  master BRESP
- BREADY_M  in  1  master BREADY
- grant  out  NUM_S  registered one-hot grant; 0 when idle
- aw_full  out  NUM_S  counter of slave i is at its maximum; the AW path must stall writes to slave i
- err  out  1  sticky protocol-error flag

## Operation
- Counters cnt[i]:
  - +1 on aw_fire & aw_sel[i].
  - −1 on a B handshake of slave i (grant[i] & BVALID_S[i] & BREADY_M).
  - Both in the same cycle: cnt[i] unchanged.
- Saturation: an increment while cnt[i] = 2^CNTW−1 is dropped and sets err.
- A non-one-hot aw_sel with aw_fire set also sets err, and no counter changes.
- err clears only on reset.
- Eligibility: eligible[i] = BVALID_S[i] & (cnt[i] != 0). A BVALID from a slave with no pending write is ignored and never forwarded.
- FSM states:
  - IDLE: grant = 0. If any slave is eligible, grant the first eligible slave searching upward from last+1 (wrapping), load grant, and go to BUSY.
  - BUSY: BVALID_M = BVALID_S[grant]; BID_M/BRESP_M are taken from the granted slave; BREADY_S = grant & {NUM_S{BREADY_M}}. The grant holds until BVALID_M & BREADY_M. On the handshake, last ← granted index and the FSM goes to IDLE (see Configuration for the alternative).
- In IDLE: BVALID_M = 0, BID_M = 0, BRESP_M = 0, BREADY_S = 0.
- ARESET mid-transaction: all state clears immediately. An in-flight response is dropped; the system resets the slaves together with this block.
- Reset values:
  - grant = 0, BVALID_M = 0, BID_M = 0, BRESP_M = 0, BREADY_S = 0.
  - cnt = 0, aw_full = 0, err = 0.
  - last = NUM_S−1, so slave 0 has first priority.

## Timing
- Eligible at cycle t in IDLE → grant is registered at the edge ending t → BVALID_M is high in cycle t+1.
- BVALID_M, BID_M, BRESP_M and BREADY_S are combinational from the registered grant and the slave inputs. There is no extra register stage.
- Handshake at cycle t → the counter decrement is visible at t+1.
- The next grant takes effect at t+2 by default, or at t+1 with back-to-back enabled.
- aw_full is a combinational decode of the registered counters.
- The grant never changes while BVALID_M & !BREADY_M.

## Configuration
- AXI_B_BACK2BACK_EN defined:
  - On a handshake in BUSY, the arbiter evaluates eligibility in the same cycle, excluding the current slave's decrementing entry (its cnt is treated as cnt−1).
  - If another slave, or the same slave with cnt>1 and BVALID held, is eligible, the FSM loads the new round-robin grant and stays in BUSY. There is zero bubble between responses.
- Undefined: a single-cycle IDLE bubble is inserted after every handshake.

## Structure
- Shared package axi_pkg:
  - BRESP encodings OKAY/EXOKAY/SLVERR/DECERR
  - default IDW
  - arb_state_t enum {IDLE, BUSY}
- Sub-module rr_pick: combinational round-robin picker. Inputs are the request vector and the last index; outputs are the one-hot winner and a valid flag. It is parametrised by NUM_S and reusable by the R-channel arbiter.

## Test plan
- Reset, then aw_fire to slave 1; BVALID_S[1]=1 at t, BREADY_M=1 → grant=3'b010 and BVALID_M=1 at t+1; handshake → cnt[1]=0 and grant=0 at t+2 (no BACK2BACK).
- BVALID_S=3'b111 with no AW issued → BVALID_M stays 0, grant stays 0, err stays 0.
- One write pending on each of slaves 0, 1 and 2, all BVALID held, BREADY_M=1 → service order 0,1,2. With AXI_B_BACK2BACK_EN the handshakes fall on consecutive cycles; without it they are spaced two cycles apart.
- Granted slave 2 with BREADY_M=0 for 5 cycles while slave 0 becomes eligible → grant stays 3'b100 and BID_M/BRESP_M stay stable; slave 0 is served after slave 2's handshake.
- CNTW=2: issue 3 AWs to slave 0 → aw_full[0]=1; a 4th aw_fire → cnt stays 3 and err=1, sticky until ARESET.
- Assert ARESET while in BUSY with BVALID_M=1 → grant, BVALID_M, cnt and err are all 0 in the same cycle; after release, the first pick is slave 0.
